// File: rtl/stt8_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package stt8_pkg;

   localparam int STT8_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stt8_state_e;

   function automatic int stt8_cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between the tile inputs and the serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow into the next bit.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a borrow flop between bits.
//
// state | meaning
// IDLE  | waiting for start; previous result held
// RUN   | shifting one bit per clock through the full subtractor
// DONE  | one cycle, done pulsed, result presented
module serial_subtractor
   import stt8_pkg::*;
#(
   parameter int WIDTH = STT8_DEFAULT_WIDTH
) (
   input logic              clk,
   input logic              rst,
   serial_subtractor_if.slave bus
);
   localparam int CNT_W = stt8_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   stt8_state_e      state_q;
   logic [WIDTH-1:0] ra_q, rb_q, diff_q;
   logic [WIDTH-1:0] ra_d, rb_d, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q;
   logic             busy_q, done_q, borrow_q;
   logic             bit_d, bit_bo;

   full_subtractor u_fs (
      .a    (ra_q[0]),
      .b    (rb_q[0]),
      .bin  (br_q),
      .d    (bit_d),
      .bout (bit_bo)
   );

   assign ra_d   = {1'b0, ra_q[WIDTH-1:1]};
   assign rb_d   = {1'b0, rb_q[WIDTH-1:1]};
   assign diff_d = {bit_d, diff_q[WIDTH-1:1]};
   assign cnt_d  = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q  <= RUN;
                  busy_q   <= 1'b1;
                  ra_q     <= bus.a;
                  rb_q     <= bus.b;
                  diff_q   <= '0;
                  cnt_q    <= '0;
                  br_q     <= 1'b0;
                  borrow_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               ra_q   <= ra_d;
               rb_q   <= rb_d;
               diff_q <= diff_d;
               br_q   <= bit_bo;
               cnt_q  <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  borrow_q <= bit_bo;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at the default 8-bit width.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Launch one operation and sample until done; returns cycles from acceptance.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int busy_cnt, output bit seen);
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0; busy_cnt = 0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.done === 1'b1) seen = 1'b1;
         else begin
            lat++;
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.done); end
      total++; if (bus.diff !== 8'd0) begin bad++; $display("FAIL reset_diff got=%0d want=0", bus.diff); end
      total++; if (bus.borrow_out !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%0b want=0", bus.borrow_out); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bc; bit seen;
      run_op(8'd200, 8'd55, lat, bc, seen);
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%0b want=1", seen); end
      total++; if (lat != 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
      total++; if (bc != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bc); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%0b want=0", bus.busy); end
      total++; if (bus.diff !== 8'd145) begin bad++; $display("FAIL basic_diff got=%0d want=145", bus.diff); end
      total++; if (bus.borrow_out !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%0b want=0", bus.borrow_out); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%0b want=0", bus.done); end
      repeat (3) @(negedge clk);
      total++; if (bus.diff !== 8'd145) begin bad++; $display("FAIL basic_hold got=%0d want=145", bus.diff); end
   endtask

   task automatic test_borrow();
      int lat, bc; bit seen;
      run_op(8'd5, 8'd10, lat, bc, seen);
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL borrow_timeout got=%0b want=1", seen); end
      total++; if (bus.diff !== 8'd251) begin bad++; $display("FAIL borrow_diff got=%0d want=251", bus.diff); end
      total++; if (bus.borrow_out !== 1'b1) begin bad++; $display("FAIL borrow_flag got=%0b want=1", bus.borrow_out); end
   endtask

   task automatic test_edges();
      int lat, bc; bit seen;
      logic [W-1:0] av [3] = '{8'hFF, 8'h00, 8'h00};
      logic [W-1:0] bv [3] = '{8'hFF, 8'h00, 8'h01};
      logic [W-1:0] dv [3] = '{8'h00, 8'h00, 8'hFF};
      logic         ov [3] = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         run_op(av[k], bv[k], lat, bc, seen);
         total++; if (seen !== 1'b1) begin bad++; $display("FAIL edge%0d_timeout got=%0b want=1", k, seen); end
         total++; if (bus.diff !== dv[k]) begin bad++; $display("FAIL edge%0d_diff got=%0h want=%0h", k, bus.diff, dv[k]); end
         total++; if (bus.borrow_out !== ov[k]) begin bad++; $display("FAIL edge%0d_borrow got=%0b want=%0b", k, bus.borrow_out, ov[k]); end
      end
   endtask

   task automatic test_ignore_start();
      int dones = 0;
      @(negedge clk);
      bus.a = 8'd100; bus.b = 8'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.a = 8'd9; bus.b = 8'd9; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (bus.done === 1'b1) dones++;
         @(negedge clk);
      end
      total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
      total++; if (bus.diff !== 8'd99) begin bad++; $display("FAIL ignore_diff got=%0d want=99", bus.diff); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_idle_busy got=%0b want=0", bus.busy); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bc, dones = 0; bit seen;
      @(negedge clk);
      bus.a = 8'd100; bus.b = 8'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0b want=0", bus.done); end
      total++; if (bus.diff !== 8'd0) begin bad++; $display("FAIL rstmid_diff got=%0d want=0", bus.diff); end
      total++; if (bus.borrow_out !== 1'b0) begin bad++; $display("FAIL rstmid_borrow got=%0b want=0", bus.borrow_out); end
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) dones++;
         @(negedge clk);
      end
      total++; if (dones != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
      run_op(8'd7, 8'd3, lat, bc, seen);
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_restart_timeout got=%0b want=1", seen); end
      total++; if (bus.diff !== 8'd4) begin bad++; $display("FAIL rstmid_restart_diff got=%0d want=4", bus.diff); end
   endtask

   task automatic test_back_to_back();
      int dones = 0, last = -1;
      bit check_busy = 1'b0;
      @(negedge clk);
      bus.a = 8'd50; bus.b = 8'd20; bus.start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (check_busy) begin
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_rebusy got=%0b want=1 at=%0d", bus.busy, i); end
            check_busy = 1'b0;
         end
         if (bus.done === 1'b1) begin
            dones++;
            total++; if (bus.diff !== 8'd30) begin bad++; $display("FAIL b2b_diff got=%0d want=30 at=%0d", bus.diff, i); end
            if (last >= 0) begin
               total++; if (i - last != 9) begin bad++; $display("FAIL b2b_interval got=%0d want=9", i - last); end
            end else begin
               total++; if (i != 8) begin bad++; $display("FAIL b2b_first got=%0d want=8", i); end
            end
            last = i;
            check_busy = 1'b1;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      total++; if (dones != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", dones); end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      test_reset();
      test_basic();
      test_borrow();
      test_edges();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
